id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS core, with load-use hazard detection and bubble insertion.
- Captures decoded control, operands and register specifiers each cycle, and drives the EX stage.
- Its rse_ex/rte_ex outputs feed the EX forwarding unit directly.
- Asserts stall_f/stall_d when a load in EX feeds the instruction in ID, and inserts a bubble; also honours an external EX flush from branch resolution.

---
 rtl/id_ex_stage_pkg.sv | 15 +
 rtl/id_ex_stage_load_use_detect.sv | 22 ++
 rtl/id_ex_stage.sv | 93 +++++++++
 tb/tb_id_ex_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared ID/EX pipeline constants
package id_ex_stage_pkg;

  localparam int CTRL_W        = 8;
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 3;
  localparam int CTRL_ALUCTL_MSB = 2;
  localparam int CTRL_ALUCTL_LSB = 0;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 8'h00;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard detect
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              valid_d,
  input  logic              valid_e,
  input  logic              memtoreg_e,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rte_ex,
  output logic              lwstall
);

  logic rte_nonzero;
  logic src_match;

  // rt_d is compared even for I-type users; the extra stall is harmless
  assign rte_nonzero = |rte_ex;
  assign src_match   = (rs_d == rte_ex) | (rt_d == rte_ex);
  assign lwstall     = valid_d & valid_e & memtoreg_e & rte_nonzero & src_match;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] rd1_d,
  input  logic [DATA_W-1:0] rd2_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic [DATA_W-1:0] signimm_d,
  input  logic              flush_e,
  output logic              valid_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [DATA_W-1:0] rd1_e,
  output logic [DATA_W-1:0] rd2_e,
  output logic [REG_AW-1:0] rse_ex,
  output logic [REG_AW-1:0] rte_ex,
  output logic [REG_AW-1:0] rde_ex,
  output logic [DATA_W-1:0] signimm_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic lwstall;
  logic bubble;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .valid_d    (valid_d),
    .valid_e    (valid_e),
    .memtoreg_e (ctrl_e[CTRL_MEMTOREG]),
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .rte_ex     (rte_ex),
    .lwstall    (lwstall)
  );

  assign stall_f = lwstall;
  assign stall_d = lwstall;
  assign bubble  = flush_e | lwstall;

  // Bubbles zero the specifiers too so the forwarding unit sees no match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_e   <= 1'b0;
      ctrl_e    <= CTRL_BUBBLE;
      rd1_e     <= '0;
      rd2_e     <= '0;
      rse_ex    <= '0;
      rte_ex    <= '0;
      rde_ex    <= '0;
      signimm_e <= '0;
    end else if (bubble) begin
      valid_e   <= 1'b0;
      ctrl_e    <= CTRL_BUBBLE;
      rd1_e     <= '0;
      rd2_e     <= '0;
      rse_ex    <= '0;
      rte_ex    <= '0;
      rde_ex    <= '0;
      signimm_e <= '0;
    end else begin
      valid_e   <= valid_d;
      ctrl_e    <= valid_d ? ctrl_d : CTRL_BUBBLE;
      rd1_e     <= rd1_d;
      rd2_e     <= rd2_d;
      rse_ex    <= rs_d;
      rte_ex    <= rt_d;
      rde_ex    <= rd_d;
      signimm_e <= signimm_d;
    end
  end

  // Counts load-use stalls only; flushes are not bubbles of interest here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (lwstall && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 8;

  localparam logic [7:0] LW  = 8'hD2;
  localparam logic [7:0] ADD = 8'h8A;

  typedef struct packed {
    logic              valid;
    logic [7:0]        ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] imm;
    logic [CNT_W-1:0]  cnt;
  } ex_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid_d = 1'b0;
  logic [7:0]        ctrl_d = '0;
  logic [DATA_W-1:0] rd1_d = '0;
  logic [DATA_W-1:0] rd2_d = '0;
  logic [REG_AW-1:0] rs_d = '0;
  logic [REG_AW-1:0] rt_d = '0;
  logic [REG_AW-1:0] rd_d = '0;
  logic [DATA_W-1:0] signimm_d = '0;
  logic              flush_e = 1'b0;
  logic              valid_e;
  logic [7:0]        ctrl_e;
  logic [DATA_W-1:0] rd1_e;
  logic [DATA_W-1:0] rd2_e;
  logic [REG_AW-1:0] rse_ex;
  logic [REG_AW-1:0] rte_ex;
  logic [REG_AW-1:0] rde_ex;
  logic [DATA_W-1:0] signimm_e;
  logic              stall_f;
  logic              stall_d;
  logic [CNT_W-1:0]  bubble_cnt;

  int   checks = 0;
  int   errors = 0;
  ex_t  model;
  ex_t  exp_q[$];

  id_ex_stage #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_d    (valid_d),
    .ctrl_d     (ctrl_d),
    .rd1_d      (rd1_d),
    .rd2_d      (rd2_d),
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .rd_d       (rd_d),
    .signimm_d  (signimm_d),
    .flush_e    (flush_e),
    .valid_e    (valid_e),
    .ctrl_e     (ctrl_e),
    .rd1_e      (rd1_e),
    .rd2_e      (rd2_e),
    .rse_ex     (rse_ex),
    .rte_ex     (rte_ex),
    .rde_ex     (rde_ex),
    .signimm_e  (signimm_e),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic check_ex(input string tag, input ex_t e);
    check({tag, ".valid_e"},    valid_e,    e.valid);
    check({tag, ".ctrl_e"},     ctrl_e,     e.ctrl);
    check({tag, ".rd1_e"},      rd1_e,      e.rd1);
    check({tag, ".rd2_e"},      rd2_e,      e.rd2);
    check({tag, ".rse_ex"},     rse_ex,     e.rs);
    check({tag, ".rte_ex"},     rte_ex,     e.rt);
    check({tag, ".rde_ex"},     rde_ex,     e.rd);
    check({tag, ".signimm_e"},  signimm_e,  e.imm);
    check({tag, ".bubble_cnt"}, bubble_cnt, e.cnt);
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic fl);
    valid_d   = v;
    ctrl_d    = c;
    rs_d      = rs;
    rt_d      = rt;
    rd_d      = rd;
    flush_e   = fl;
    rd1_d     = $urandom;
    rd2_d     = $urandom;
    signimm_d = $urandom;
  endtask

  // Reference: predicts stall now and the EX register after the next edge
  task automatic cycle(input string tag);
    logic lw;
    ex_t  nxt;
    #1;
    lw = valid_d & model.valid & model.ctrl[6] & (model.rt != 0) &
         ((rs_d == model.rt) | (rt_d == model.rt));
    check({tag, ".stall_f"}, stall_f, lw);
    check({tag, ".stall_d"}, stall_d, lw);
    nxt = '0;
    nxt.cnt = (lw && model.cnt != {CNT_W{1'b1}}) ? model.cnt + 1'b1 : model.cnt;
    if (!(flush_e || lw)) begin
      nxt.valid = valid_d;
      nxt.ctrl  = valid_d ? ctrl_d : 8'h00;
      nxt.rd1   = rd1_d;
      nxt.rd2   = rd2_d;
      nxt.rs    = rs_d;
      nxt.rt    = rt_d;
      nxt.rd    = rd_d;
      nxt.imm   = signimm_d;
    end
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 0, 1);
    end else begin
      model = exp_q.pop_front();
      check_ex(tag, model);
    end
  endtask

  initial begin
    ex_t zero;
    zero  = '0;
    model = '0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      @(posedge clk);
      #1;
      check("reset.stall_f", stall_f, 0);
      check_ex("reset", zero);
    end
    rst_n = 1'b1;

    drive(1, 8'h88, 3, 4, 5, 0);
    cycle("first");
    check("first.rse_ex_const", rse_ex, 5'd3);

    // Load-use: stall one cycle then advance
    drive(1, LW, 1, 8, 0, 0);
    cycle("lw");
    drive(1, ADD, 8, 2, 9, 0);
    cycle("lu_stall");
    check("lu_stall.cnt_const", bubble_cnt, 1);
    cycle("lu_adv");
    check("lu_adv.valid_const", valid_e, 1);

    // r0 immunity
    drive(1, LW, 1, 0, 0, 0);
    cycle("r0_lw");
    drive(1, ADD, 0, 2, 9, 0);
    cycle("r0_use");

    // Non-load producer: forwarding, no stall
    drive(1, ADD, 1, 8, 8, 0);
    cycle("alu_prod");
    drive(1, ADD, 8, 8, 9, 0);
    cycle("alu_use");

    // Invalid ID slot: fields captured, ctrl forced off
    drive(0, 8'hFF, 6, 7, 10, 0);
    cycle("invalid");

    // Flush alone, then flush coincident with load-use
    drive(1, ADD, 4, 5, 6, 1);
    cycle("flush");
    drive(1, LW, 2, 12, 0, 0);
    cycle("flush_lw");
    drive(1, ADD, 3, 12, 13, 1);
    cycle("flush_and_stall");
    check("flush_and_stall.cnt_const", bubble_cnt, 2);
    flush_e = 1'b0;
    cycle("flush_and_stall_adv");

    // Saturation of the bubble counter
    for (int i = 0; i < (1 << CNT_W) + 4; i++) begin
      drive(1, LW, 1, 9, 0, 0);
      cycle("sat_lw");
      drive(1, ADD, 9, 1, 2, 0);
      cycle("sat_use");
    end
    check("sat.cnt_const", bubble_cnt, {CNT_W{1'b1}});

    // Asynchronous reset mid-stall
    drive(1, LW, 1, 11, 0, 0);
    cycle("ar_lw");
    drive(1, ADD, 11, 2, 3, 0);
    #1;
    check("ar.stall_before", stall_f, 1);
    rst_n = 1'b0;
    #1;
    check("ar.stall_f", stall_f, 0);
    check("ar.stall_d", stall_d, 0);
    check_ex("ar", zero);
    model = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, ADD, 11, 2, 3, 0);
    cycle("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
